// File: rtl/rtc_multi_alarm.sv
// rtc_multi_alarm: 24-h binary real-time clock with NUM_ALARMS alarm channels, 12/24-h display and ring timeout.
// Snooze support is compiled in only when RTC_SNOOZE_EN is defined.
module rtc_multi_alarm #(
   parameter int CLOCK_FREQ = 50000000,
   parameter int NUM_ALARMS = 4,
   parameter int RING_SEC   = 60,
   parameter int SNOOZE_SEC = 300,
   localparam int AW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  time_set,
   input  logic [7:0]            set_hours,
   input  logic [7:0]            set_minutes,
   input  logic [7:0]            set_seconds,
   input  logic                  alarm_wr,
   input  logic [AW-1:0]         alarm_idx,
   input  logic [7:0]            alarm_hours,
   input  logic [7:0]            alarm_minutes,
   input  logic [7:0]            alarm_seconds,
   input  logic                  alarm_en_in,
   input  logic                  snooze,
   input  logic                  dismiss,
   input  logic                  mode_12h,
   output logic [7:0]            hours,
   output logic [7:0]            minutes,
   output logic [7:0]            seconds,
   output logic                  am_pm,
   output logic                  tick_1hz,
   output logic [NUM_ALARMS-1:0] alarm_ring,
   output logic                  alarm_any
);
   localparam int PW   = $clog2(CLOCK_FREQ);
   localparam int CMAX = (RING_SEC > SNOOZE_SEC) ? RING_SEC : SNOOZE_SEC;
   localparam int CW   = $clog2(CMAX + 1);
   typedef enum logic [1:0] {IDLE, RINGING, SNOOZED} state_t;
   logic [PW-1:0]         presc_q, presc_d;
   logic [7:0]            hr_q, hr_d, min_q, min_d, sec_q, sec_d;
   logic [7:0]            ahr_q [NUM_ALARMS];
   logic [7:0]            ahr_d [NUM_ALARMS];
   logic [7:0]            amin_q [NUM_ALARMS];
   logic [7:0]            amin_d [NUM_ALARMS];
   logic [7:0]            asec_q [NUM_ALARMS];
   logic [7:0]            asec_d [NUM_ALARMS];
   logic [NUM_ALARMS-1:0] en_q, en_d;
   state_t                st_q [NUM_ALARMS];
   state_t                st_d [NUM_ALARMS];
   logic [CW-1:0]         cnt_q [NUM_ALARMS];
   logic [CW-1:0]         cnt_d [NUM_ALARMS];
   logic                  tick, load, adv, wr_ok, s_wrap, m_wrap;
   logic [7:0]            hr_inc, min_inc, sec_inc;
`ifndef RTC_SNOOZE_EN
   logic                  unused_snooze;
   assign unused_snooze = snooze;
`endif
   assign tick    = presc_q == PW'(CLOCK_FREQ - 1);
   assign load    = time_set && set_hours < 8'd24 && set_minutes < 8'd60 && set_seconds < 8'd60;
   // a valid load in a tick cycle suppresses both the advance and alarm matching
   assign adv     = tick && !load;
   assign wr_ok   = alarm_wr && alarm_hours < 8'd24 && alarm_minutes < 8'd60 &&
                    alarm_seconds < 8'd60 && int'(alarm_idx) < NUM_ALARMS;
   assign s_wrap  = sec_q == 8'd59;
   assign m_wrap  = s_wrap && min_q == 8'd59;
   assign sec_inc = s_wrap ? 8'd0 : sec_q + 8'd1;
   assign min_inc = s_wrap ? (min_q == 8'd59 ? 8'd0 : min_q + 8'd1) : min_q;
   assign hr_inc  = m_wrap ? (hr_q == 8'd23 ? 8'd0 : hr_q + 8'd1) : hr_q;
   assign hours    = !mode_12h ? hr_q : hr_q == 8'd0 ? 8'd12 : hr_q > 8'd12 ? hr_q - 8'd12 : hr_q;
   assign am_pm    = mode_12h && hr_q >= 8'd12;
   assign minutes  = min_q;
   assign seconds  = sec_q;
   assign tick_1hz = tick;
   assign alarm_any = |alarm_ring;
   always_comb begin
      presc_d = (load || tick) ? '0 : presc_q + 1'b1;
      hr_d    = load ? set_hours   : adv ? hr_inc  : hr_q;
      min_d   = load ? set_minutes : adv ? min_inc : min_q;
      sec_d   = load ? set_seconds : adv ? sec_inc : sec_q;
      en_d    = en_q;
      for (int i = 0; i < NUM_ALARMS; i++) begin
         ahr_d[i]      = ahr_q[i];
         amin_d[i]     = amin_q[i];
         asec_d[i]     = asec_q[i];
         st_d[i]       = st_q[i];
         cnt_d[i]      = cnt_q[i];
         alarm_ring[i] = st_q[i] == RINGING;
         if (wr_ok && alarm_idx == AW'(i)) begin
            ahr_d[i]  = alarm_hours;
            amin_d[i] = alarm_minutes;
            asec_d[i] = alarm_seconds;
            en_d[i]   = alarm_en_in;
            st_d[i]   = IDLE;
            cnt_d[i]  = '0;
         end else if (dismiss && st_q[i] != IDLE) begin
            st_d[i] = IDLE;
`ifdef RTC_SNOOZE_EN
         end else if (snooze && st_q[i] == RINGING) begin
            st_d[i]  = SNOOZED;
            cnt_d[i] = CW'(SNOOZE_SEC);
`endif
         end else if (adv && st_q[i] == IDLE) begin
            if (en_q[i] && hr_inc == ahr_q[i] && min_inc == amin_q[i] && sec_inc == asec_q[i]) begin
               st_d[i]  = RINGING;
               cnt_d[i] = CW'(RING_SEC);
            end
         end else if (adv) begin
            cnt_d[i] = cnt_q[i] - 1'b1;
            if (cnt_q[i] == CW'(1)) begin
               st_d[i]  = st_q[i] == RINGING ? IDLE : RINGING;
               cnt_d[i] = st_q[i] == RINGING ? '0 : CW'(RING_SEC);
            end
         end
      end
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         presc_q <= '0;
         hr_q    <= '0;
         min_q   <= '0;
         sec_q   <= '0;
         en_q    <= '0;
         for (int i = 0; i < NUM_ALARMS; i++) begin
            ahr_q[i]  <= '0;
            amin_q[i] <= '0;
            asec_q[i] <= '0;
            st_q[i]   <= IDLE;
            cnt_q[i]  <= '0;
         end
      end else begin
         presc_q <= presc_d;
         hr_q    <= hr_d;
         min_q   <= min_d;
         sec_q   <= sec_d;
         en_q    <= en_d;
         for (int i = 0; i < NUM_ALARMS; i++) begin
            ahr_q[i]  <= ahr_d[i];
            amin_q[i] <= amin_d[i];
            asec_q[i] <= asec_d[i];
            st_q[i]   <= st_d[i];
            cnt_q[i]  <= cnt_d[i];
         end
      end
   end
endmodule

// File: tb/tb_rtc_multi_alarm.sv
// tb_rtc_multi_alarm: directed stimulus against a seconds-of-day behavioural model, checked every cycle.
module tb_rtc_multi_alarm;
   localparam int CF = 4, NA = 4, RS = 3, SS = 5;
`ifdef RTC_SNOOZE_EN
   localparam bit SNZ = 1'b1;
`else
   localparam bit SNZ = 1'b0;
`endif
   logic          clk = 1'b0, rst = 1'b0;
   logic          time_set = 0, alarm_wr = 0, alarm_en_in = 0, snooze = 0, dismiss = 0, mode_12h = 0;
   logic [7:0]    set_hours = 0, set_minutes = 0, set_seconds = 0;
   logic [7:0]    alarm_hours = 0, alarm_minutes = 0, alarm_seconds = 0;
   logic [1:0]    alarm_idx = 0;
   logic [7:0]    hours, minutes, seconds;
   logic          am_pm, tick_1hz, alarm_any;
   logic [NA-1:0] alarm_ring;
   int            n_cmp = 0, n_bad = 0;
   int            m_pre, m_t, m_h, m_r;
   int            m_al [NA], m_en [NA], m_st [NA], m_rem [NA];
   bit            tk, ld, adv, wok;

   always #5 clk = ~clk;

   rtc_multi_alarm #(.CLOCK_FREQ(CF), .NUM_ALARMS(NA), .RING_SEC(RS), .SNOOZE_SEC(SS)) dut (
      .clk(clk), .reset(rst), .time_set(time_set), .set_hours(set_hours), .set_minutes(set_minutes),
      .set_seconds(set_seconds), .alarm_wr(alarm_wr), .alarm_idx(alarm_idx), .alarm_hours(alarm_hours),
      .alarm_minutes(alarm_minutes), .alarm_seconds(alarm_seconds), .alarm_en_in(alarm_en_in),
      .snooze(snooze), .dismiss(dismiss), .mode_12h(mode_12h), .hours(hours), .minutes(minutes),
      .seconds(seconds), .am_pm(am_pm), .tick_1hz(tick_1hz), .alarm_ring(alarm_ring), .alarm_any(alarm_any));

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // model: time as seconds of day, channel state 0 idle / 1 ringing / 2 snoozed
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_pre = 0;
         m_t   = 0;
         for (int i = 0; i < NA; i++) begin
            m_al[i] = 0; m_en[i] = 0; m_st[i] = 0; m_rem[i] = 0;
         end
      end else begin
         tk  = m_pre == CF - 1;
         ld  = time_set && set_hours < 24 && set_minutes < 60 && set_seconds < 60;
         adv = tk && !ld;
         wok = alarm_wr && alarm_hours < 24 && alarm_minutes < 60 && alarm_seconds < 60 && alarm_idx < NA;
         m_pre = (ld || tk) ? 0 : m_pre + 1;
         if (ld) m_t = set_hours * 3600 + set_minutes * 60 + set_seconds;
         else if (tk) m_t = (m_t + 1) % 86400;
         for (int i = 0; i < NA; i++) begin
            if (wok && alarm_idx == i) begin
               m_al[i] = alarm_hours * 3600 + alarm_minutes * 60 + alarm_seconds;
               m_en[i] = alarm_en_in; m_st[i] = 0; m_rem[i] = 0;
            end else if (dismiss && m_st[i] != 0) m_st[i] = 0;
            else if (SNZ && snooze && m_st[i] == 1) begin
               m_st[i] = 2; m_rem[i] = SS;
            end else if (adv) begin
               if (m_st[i] == 0) begin
                  if (m_en[i] != 0 && m_t == m_al[i]) begin m_st[i] = 1; m_rem[i] = RS; end
               end else begin
                  m_rem[i]--;
                  if (m_rem[i] == 0) begin
                     m_st[i]  = (m_st[i] == 1) ? 0 : 1;
                     m_rem[i] = (m_st[i] == 1) ? RS : 0;
                  end
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      m_h = m_t / 3600;
      m_r = 0;
      for (int i = 0; i < NA; i++) if (m_st[i] == 1) m_r |= 1 << i;
      chk("model_hours", hours, mode_12h ? ((m_h % 12 == 0) ? 12 : m_h % 12) : m_h);
      chk("model_minutes", minutes, (m_t / 60) % 60);
      chk("model_seconds", seconds, m_t % 60);
      chk("model_am_pm", am_pm, int'(mode_12h && m_h >= 12));
      chk("model_tick", tick_1hz, int'(m_pre == CF - 1));
      chk("model_ring", alarm_ring, m_r);
      chk("model_any", alarm_any, int'(m_r != 0));
   end

   task automatic pulse_set(input int h, input int m, input int s);
      set_hours = 8'(h); set_minutes = 8'(m); set_seconds = 8'(s); time_set = 1;
      @(posedge clk); #1 time_set = 0;
   endtask

   task automatic pulse_wr(input int idx, input int h, input int m, input int s, input bit en);
      alarm_idx = 2'(idx); alarm_hours = 8'(h); alarm_minutes = 8'(m); alarm_seconds = 8'(s);
      alarm_en_in = en; alarm_wr = 1;
      @(posedge clk); #1 alarm_wr = 0;
   endtask

   task automatic pulse_snooze();
      snooze = 1; @(posedge clk); #1 snooze = 0;
   endtask

   task automatic pulse_dismiss();
      dismiss = 1; @(posedge clk); #1 dismiss = 0;
   endtask

   // returns at the falling edge inside the n-th tick cycle, before its advancing edge
   task automatic wait_ticks(input int n);
      for (int k = 0; k < n; k++) begin
         int c;
         c = 0;
         do begin @(negedge clk); c++; end while (!tick_1hz && c < 3 * CF);
         if (!tick_1hz) begin
            n_cmp++; n_bad++;
            $display("FAIL wait_tick: got no tick_1hz expected one within %0d cycles", 3 * CF);
         end
      end
   endtask

   initial begin
      int cnt;
      #1 rst = 1; mode_12h = 1;
      repeat (3) @(negedge clk);
      chk("reset_hours12", hours, 12);
      chk("reset_am_pm", am_pm, 0);
      chk("reset_ring", alarm_ring, 0);
      chk("reset_tick", tick_1hz, 0);
      #2 rst = 0;
      cnt = 0;
      repeat (16) begin @(negedge clk); if (tick_1hz) cnt++; end
      chk("tick_period", cnt, 4);
      pulse_set(23, 59, 58);
      wait_ticks(2);
      @(negedge clk);
      chk("wrap_hours12", hours, 12);
      chk("wrap_minutes", minutes, 0);
      chk("wrap_seconds", seconds, 0);
      chk("wrap_am", am_pm, 0);
      pulse_set(13, 5, 0);
      @(negedge clk);
      chk("pm_hours", hours, 1);
      chk("pm_flag", am_pm, 1);
      mode_12h = 0;
      #1;
      chk("h24_hours", hours, 13);
      chk("h24_am_pm", am_pm, 0);
      pulse_wr(2, 7, 0, 0, 1);
      pulse_set(6, 59, 59);
      wait_ticks(1);
      @(negedge clk);
      chk("ch2_ring", alarm_ring, 4'b0100);
      wait_ticks(3);
      chk("ch2_last_tick", alarm_ring, 4'b0100);
      @(negedge clk);
      chk("ch2_timeout", alarm_ring, 0);
      pulse_wr(0, 8, 0, 0, 1);
      pulse_set(7, 59, 59);
      wait_ticks(1);
      @(negedge clk);
      chk("ch0_ring", alarm_ring, 4'b0001);
      pulse_snooze();
      @(negedge clk);
`ifdef RTC_SNOOZE_EN
      chk("snooze_drop", alarm_ring, 0);
      wait_ticks(5);
      chk("snooze_gap", alarm_ring, 0);
      @(negedge clk);
      chk("snooze_reassert", alarm_ring, 4'b0001);
      pulse_snooze();
      @(negedge clk);
      chk("snooze_again", alarm_ring, 0);
`else
      chk("snooze_ignored", alarm_ring, 4'b0001);
`endif
      pulse_dismiss();
      @(negedge clk);
      chk("dismiss", alarm_ring, 0);
      wait_ticks(6);
      @(negedge clk);
      chk("dismiss_stays", alarm_ring, 0);
      pulse_wr(0, 9, 0, 0, 1);
      pulse_wr(3, 9, 0, 0, 1);
      pulse_set(8, 59, 59);
      wait_ticks(1);
      @(negedge clk);
      chk("dual_ring", alarm_ring, 4'b1001);
      chk("dual_any", alarm_any, 1);
      pulse_wr(0, 25, 0, 0, 1);
      @(negedge clk);
      chk("bad_wr_ignored", alarm_ring, 4'b1001);
      pulse_wr(3, 9, 0, 0, 1);
      @(negedge clk);
      chk("wr_drops_ch3", alarm_ring, 4'b0001);
      #2 rst = 1;
      #1;
      chk("async_rst_ring", alarm_ring, 0);
      chk("async_rst_hours", hours, 0);
      chk("async_rst_any", alarm_any, 0);
      #2 rst = 0;
      pulse_set(10, 20, 30);
      pulse_set(24, 0, 0);
      @(negedge clk);
      chk("bad_set_hours", hours, 10);
      chk("bad_set_minutes", minutes, 20);
      chk("bad_set_seconds", seconds, 30);
      wait_ticks(1);
      pulse_set(11, 11, 11);
      @(negedge clk);
      chk("set_on_tick", seconds, 11);
      wait_ticks(1);
      @(negedge clk);
      chk("after_set_tick", seconds, 12);
      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
